wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 23 ++
 rtl/wb_scoreboard.sv | 44 ++++
 rtl/wb_arbiter.sv | 95 +++++++++
 tb/tb_wb_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared register-file constants and types for the write-back arbiter slice.
// Provides the register-address and data widths, register count, enable
// levels, the zero word, and the requester index encoding (REQ_ALU/REQ_LSU).
package wb_arbiter_pkg;

  localparam int unsigned RegAddrWidth = 5;
  localparam int unsigned DataWidth    = 32;
  localparam int unsigned RegSize      = 32;

  typedef logic [RegAddrWidth-1:0] reg_addr_t;
  typedef logic [DataWidth-1:0]    data_t;

  localparam logic  Enable   = 1'b1;
  localparam logic  Disable  = 1'b0;
  localparam data_t ZeroWord = '0;

  // Requester index; also the encoding of the round-robin pointer.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Register busy scoreboard.
// Ports:
//   clk, rst              clock, synchronous active-high reset (clears all bits)
//   set_en, set_addr      mark a destination register busy on the next edge
//   clr_en, clr_addr      mark a register free on the next edge
//   chk_addr1, chk_addr2  lookup addresses
//   busy1, busy2          busy state of the looked-up registers
// Register 0 is never busy; a set and a clear of the same register on the
// same edge leaves it busy.
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t chk_addr1,
  input  reg_addr_t chk_addr2,
  output logic      busy1,
  output logic      busy2
);

  logic [RegSize-1:0] busy;
  logic [RegSize-1:0] busy_next;

  // Clear is applied first so that a coincident set wins.
  always_comb begin
    busy_next = busy;
    if (clr_en && clr_addr != '0) busy_next[clr_addr] = 1'b0;
    if (set_en && set_addr != '0) busy_next[set_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  assign busy1 = busy[chk_addr1];
  assign busy2 = busy[chk_addr2];

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares the single register-file write port between the
// ALU and the LSU with round-robin priority on conflicts.
// Parameter RR_INIT: requester holding first priority after reset (0 ALU, 1 LSU).
// Ports:
//   clk, rst                             clock, synchronous active-high reset
//   alu_valid/alu_waddr/alu_wdata/alu_ready   ALU write request handshake
//   lsu_valid/lsu_waddr/lsu_wdata/lsu_ready   LSU write request handshake
//   iss_valid, iss_addr, chk_addr1, chk_addr2, busy1, busy2
//                                        scoreboard ports, present only when
//                                        WB_SCOREBOARD_EN is defined
//   rf_we, rf_waddr, rf_wdata            registered register-file write port
// A transfer to register 0 is accepted and dropped (no write, no clear).
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int RR_INIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_waddr,
  input  logic [31:0] alu_wdata,
  output logic        alu_ready,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_waddr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_ready,
`ifdef WB_SCOREBOARD_EN
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        busy1,
  output logic        busy2,
`endif
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam req_t PtrInit = (RR_INIT == 0) ? REQ_ALU : REQ_LSU;

  req_t      ptr;
  logic      alu_grant;
  logic      lsu_grant;
  logic      xfer;
  reg_addr_t xfer_addr;
  data_t     xfer_data;

  always_comb begin
    alu_grant = !rst && alu_valid && (!lsu_valid || ptr == REQ_ALU);
    lsu_grant = !rst && lsu_valid && (!alu_valid || ptr == REQ_LSU);
    xfer      = alu_grant || lsu_grant;
    xfer_addr = lsu_grant ? lsu_waddr : alu_waddr;
    xfer_data = lsu_grant ? lsu_wdata : alu_wdata;
  end

  assign alu_ready = alu_grant;
  assign lsu_ready = lsu_grant;

  // The pointer moves past whichever requester was just served, so a conflict
  // loser always wins the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= PtrInit;
      rf_we    <= Disable;
      rf_waddr <= '0;
      rf_wdata <= ZeroWord;
    end else begin
      rf_we <= Disable;
      if (xfer) ptr <= lsu_grant ? REQ_ALU : REQ_LSU;
      if (xfer && xfer_addr != '0) begin
        rf_we    <= Enable;
        rf_waddr <= xfer_addr;
        rf_wdata <= xfer_data;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (iss_valid),
    .set_addr  (iss_addr),
    .clr_en    (xfer),
    .clr_addr  (xfer_addr),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .busy1     (busy1),
    .busy2     (busy2)
  );
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (RR_INIT=0). Scoreboard steps are included
// when WB_SCOREBOARD_EN is defined.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid;
  logic [4:0]  alu_waddr, lsu_waddr;
  logic [31:0] alu_wdata, lsu_wdata;
  logic        alu_ready, lsu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef WB_SCOREBOARD_EN
  logic        iss_valid;
  logic [4:0]  iss_addr, chk_addr1, chk_addr2;
  logic        busy1, busy2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.RR_INIT(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_waddr (alu_waddr),
    .alu_wdata (alu_wdata),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_waddr (lsu_waddr),
    .lsu_wdata (lsu_wdata),
    .lsu_ready (lsu_ready),
`ifdef WB_SCOREBOARD_EN
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .busy1     (busy1),
    .busy2     (busy2),
`endif
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
    lsu_valid = 1'b0; lsu_waddr = '0; lsu_wdata = '0;
`ifdef WB_SCOREBOARD_EN
    iss_valid = 1'b0; iss_addr = '0; chk_addr1 = '0; chk_addr2 = '0;
`endif
    tick();
    tick();

    // Reset: requests present but nothing granted or written.
    alu_valid = 1'b1; alu_waddr = 5'd1; alu_wdata = 32'h11;
    lsu_valid = 1'b1; lsu_waddr = 5'd2; lsu_wdata = 32'h22;
    #1;
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_lsu_ready", 32'(lsu_ready), 32'd0);
    tick();
    check("rst_rf_we",    32'(rf_we), 32'd0);
    check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);

    rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
    check("idle_rf_we", 32'(rf_we), 32'd0);

    // Lone ALU request.
    alu_valid = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'h1234;
    #1;
    check("lone_alu_ready", 32'(alu_ready), 32'd1);
    check("lone_lsu_ready", 32'(lsu_ready), 32'd0);
    tick();
    alu_valid = 1'b0;
    #1;
    check("lone_rf_we",    32'(rf_we), 32'd1);
    check("lone_rf_waddr", 32'(rf_waddr), 32'd5);
    check("lone_rf_wdata", rf_wdata, 32'h1234);
    check("lone_ready_drop", 32'(alu_ready), 32'd0);
    tick();
    check("hold_rf_we",    32'(rf_we), 32'd0);
    check("hold_rf_waddr", 32'(rf_waddr), 32'd5);
    check("hold_rf_wdata", rf_wdata, 32'h1234);

    // Write to x0 from the LSU: accepted, dropped. Pointer then returns to ALU.
    lsu_valid = 1'b1; lsu_waddr = 5'd0; lsu_wdata = 32'hFFFF_FFFF;
    #1;
    check("x0_lsu_ready", 32'(lsu_ready), 32'd1);
    tick();
    lsu_valid = 1'b0;
    check("x0_rf_we", 32'(rf_we), 32'd0);

    // Conflict with pointer at ALU: ALU first, LSU next.
    alu_valid = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'hA3;
    lsu_valid = 1'b1; lsu_waddr = 5'd7; lsu_wdata = 32'hB7;
    #1;
    check("cf_alu_ready", 32'(alu_ready), 32'd1);
    check("cf_lsu_ready", 32'(lsu_ready), 32'd0);
    tick();
    alu_valid = 1'b0;
    check("cf_w1_we",   32'(rf_we), 32'd1);
    check("cf_w1_addr", 32'(rf_waddr), 32'd3);
    check("cf_w1_data", rf_wdata, 32'hA3);
    #1;
    check("cf_lsu_ready2", 32'(lsu_ready), 32'd1);
    tick();
    lsu_valid = 1'b0;
    check("cf_w2_we",   32'(rf_we), 32'd1);
    check("cf_w2_addr", 32'(rf_waddr), 32'd7);
    check("cf_w2_data", rf_wdata, 32'hB7);

    // Sustained contention for 6 cycles; pointer starts at ALU again.
    alu_valid = 1'b1; alu_waddr = 5'd10; alu_wdata = 32'hAA;
    lsu_valid = 1'b1; lsu_waddr = 5'd11; lsu_wdata = 32'hBB;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_alu_ready", 32'(alu_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_lsu_ready", 32'(lsu_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check("rr_rf_we",   32'(rf_we), 32'd1);
      check("rr_rf_addr", 32'(rf_waddr), (k % 2 == 0) ? 32'd10 : 32'd11);
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
    check("rr_after_we", 32'(rf_we), 32'd0);

`ifdef WB_SCOREBOARD_EN
    // Issue to r9 marks it busy.
    iss_valid = 1'b1; iss_addr = 5'd9; chk_addr1 = 5'd9; chk_addr2 = 5'd8;
    tick();
    iss_valid = 1'b0;
    check("sb_set_busy1", 32'(busy1), 32'd1);
    check("sb_set_busy2", 32'(busy2), 32'd0);
    // Write-back to r9 with a same-edge reissue: stays busy.
    alu_valid = 1'b1; alu_waddr = 5'd9; alu_wdata = 32'h99;
    iss_valid = 1'b1; iss_addr = 5'd9;
    tick();
    iss_valid = 1'b0;
    check("sb_setwins_busy1", 32'(busy1), 32'd1);
    check("sb_setwins_we",    32'(rf_we), 32'd1);
    // Write-back to r9 alone: cleared.
    tick();
    alu_valid = 1'b0;
    check("sb_clear_busy1", 32'(busy1), 32'd0);
    // x0 issue never marks busy.
    iss_valid = 1'b1; iss_addr = 5'd0; chk_addr2 = 5'd0;
    tick();
    iss_valid = 1'b0;
    check("sb_x0_busy2", 32'(busy2), 32'd0);
    // Mark r12 busy so reset clearing is observable.
    iss_valid = 1'b1; iss_addr = 5'd12; chk_addr1 = 5'd12;
    tick();
    iss_valid = 1'b0;
    check("sb_r12_busy1", 32'(busy1), 32'd1);
`endif

    // Move pointer to LSU with a lone ALU grant, then reset during an LSU request.
    alu_valid = 1'b1; alu_waddr = 5'd2; alu_wdata = 32'h22;
    tick();
    alu_valid = 1'b0;
    check("pre_rst_we", 32'(rf_we), 32'd1);
    lsu_valid = 1'b1; lsu_waddr = 5'd4; lsu_wdata = 32'h44;
    rst = 1'b1;
    #1;
    check("mrst_lsu_ready", 32'(lsu_ready), 32'd0);
    tick();
    check("mrst_rf_we",    32'(rf_we), 32'd0);
    check("mrst_rf_waddr", 32'(rf_waddr), 32'd0);
`ifdef WB_SCOREBOARD_EN
    check("mrst_busy1", 32'(busy1), 32'd0);
`endif
    // After reset the pointer is back at ALU; LSU re-presents and follows.
    rst = 1'b0;
    alu_valid = 1'b1; alu_waddr = 5'd6; alu_wdata = 32'h66;
    #1;
    check("post_rst_alu_ready", 32'(alu_ready), 32'd1);
    check("post_rst_lsu_ready", 32'(lsu_ready), 32'd0);
    tick();
    alu_valid = 1'b0;
    check("post_rst_w1_addr", 32'(rf_waddr), 32'd6);
    #1;
    check("post_rst_lsu_ready2", 32'(lsu_ready), 32'd1);
    tick();
    lsu_valid = 1'b0;
    check("post_rst_w2_we",   32'(rf_we), 32'd1);
    check("post_rst_w2_addr", 32'(rf_waddr), 32'd4);
    check("post_rst_w2_data", rf_wdata, 32'h44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
